// File: rtl/risc_pkg.sv
// Shared types for the load/store path.
// Contents:
//   mem_size_t  access size of a memory request (BYTE, HALF_WORD, WORD)
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } mem_size_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundles the pipeline (lsu_*) request channel and the data memory (dmem_*)
// port of the store buffer.
// Modports:
//   slave  : the store buffer (accepts lsu requests, drives the dmem port)
//   master : the pipeline plus data memory around it
interface store_buffer_if;
    import risc_pkg::*;

    logic        lsu_req;
    logic        lsu_wr_en;
    mem_size_t   lsu_data_size;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wr_data;
    logic        lsu_zero_extend;
    logic        lsu_ready;
    logic [31:0] lsu_rd_data;

    logic        dmem_req;
    logic        dmem_wr_en;
    mem_size_t   dmem_data_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_zero_extend;
    logic [31:0] dmem_rd_data;

    modport slave (
        input  lsu_req, lsu_wr_en, lsu_data_size, lsu_addr, lsu_wr_data, lsu_zero_extend,
        output lsu_ready, lsu_rd_data,
        output dmem_req, dmem_wr_en, dmem_data_size, dmem_addr, dmem_wr_data, dmem_zero_extend,
        input  dmem_rd_data
    );

    modport master (
        output lsu_req, lsu_wr_en, lsu_data_size, lsu_addr, lsu_wr_data, lsu_zero_extend,
        input  lsu_ready, lsu_rd_data,
        input  dmem_req, dmem_wr_en, dmem_data_size, dmem_addr, dmem_wr_data, dmem_zero_extend,
        output dmem_rd_data
    );

endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between the memory stage and data memory.
// Stores are accepted in one cycle into a circular FIFO and drained in order
// whenever the memory port is not used by a load. Loads pass straight through
// unless they overlap a pending store, in which case they stall until the
// overlapping stores have drained.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         store_buffer_if.slave: lsu request channel and dmem port
//   sb_count    registered number of occupied entries
//   sb_empty    sb_count == 0
// Optional feature: define STORE_BUF_FWD_EN to forward store data to a load
// whose youngest overlapping entry matches it exactly in address and size.
module store_buffer
    import risc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    store_buffer_if.slave    bus,
    output logic [CNT_W-1:0] sb_count,
    output logic             sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      ent_addr [DEPTH];
    mem_size_t        ent_size [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic is_load;
    logic is_store;
    logic any_ovl;
    logic load_port;
    logic can_push;
    logic push;
    logic pop;
    logic fwd_hit;

    // Last byte offset of an access; ranges are compared in 33 bits so an
    // access near the top of the address space cannot wrap to zero.
    function automatic logic [32:0] span(input mem_size_t s);
        case (s)
            BYTE:      return 33'd0;
            HALF_WORD: return 33'd1;
            default:   return 33'd3;
        endcase
    endfunction

`ifdef STORE_BUF_FWD_EN
    logic [PTR_W-1:0] yng_idx;
    logic [31:0]      fwd_data;

    function automatic logic [31:0] extend(input logic [31:0] d, input mem_size_t s,
                                           input logic zx);
        case (s)
            BYTE:      return zx ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            HALF_WORD: return zx ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default:   return d;
        endcase
    endfunction
`endif

    assign is_load   = rst_n & bus.lsu_req & ~bus.lsu_wr_en;
    assign is_store  = rst_n & bus.lsu_req & bus.lsu_wr_en;
    assign can_push  = (count < CNT_W'(DEPTH));
    assign push      = is_store & can_push;
    assign load_port = is_load & ~any_ovl;
    // The head drains whenever a load does not own the port, including
    // while an overlapping load is stalled or being forwarded.
    assign pop       = rst_n & (count != '0) & ~load_port;

    always_comb begin : overlap_check
        logic [PTR_W-1:0] idx;
        logic [32:0]      ld_lo;
        logic [32:0]      ld_hi;
        logic [32:0]      st_lo;
        logic [32:0]      st_hi;
        idx     = '0;
        st_lo   = '0;
        st_hi   = '0;
        ld_lo   = {1'b0, bus.lsu_addr};
        ld_hi   = ld_lo + span(bus.lsu_data_size);
        any_ovl = 1'b0;
`ifdef STORE_BUF_FWD_EN
        yng_idx = head;
`endif
        // Walk oldest to youngest so the last hit is the youngest overlap.
        for (int k = 0; k < DEPTH; k++) begin
            idx   = head + PTR_W'(k);
            st_lo = {1'b0, ent_addr[idx]};
            st_hi = st_lo + span(ent_size[idx]);
            if ((CNT_W'(k) < count) && (st_lo <= ld_hi) && (ld_lo <= st_hi)) begin
                any_ovl = 1'b1;
`ifdef STORE_BUF_FWD_EN
                yng_idx = idx;
`endif
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign fwd_hit  = is_load & any_ovl
                    & (ent_addr[yng_idx] == bus.lsu_addr)
                    & (ent_size[yng_idx] == bus.lsu_data_size);
    assign fwd_data = extend(ent_data[yng_idx], ent_size[yng_idx], bus.lsu_zero_extend);
`else
    assign fwd_hit  = 1'b0;
`endif

    always_comb begin
        bus.lsu_ready        = 1'b0;
        bus.lsu_rd_data      = '0;
        bus.dmem_req         = 1'b0;
        bus.dmem_wr_en       = 1'b0;
        bus.dmem_data_size   = BYTE;
        bus.dmem_addr        = '0;
        bus.dmem_wr_data     = '0;
        bus.dmem_zero_extend = 1'b0;
        if (load_port) begin
            bus.dmem_req         = 1'b1;
            bus.dmem_data_size   = bus.lsu_data_size;
            bus.dmem_addr        = bus.lsu_addr;
            bus.dmem_wr_data     = bus.lsu_wr_data;
            bus.dmem_zero_extend = bus.lsu_zero_extend;
            bus.lsu_ready        = 1'b1;
            bus.lsu_rd_data      = bus.dmem_rd_data;
        end else begin
            if (pop) begin
                bus.dmem_req       = 1'b1;
                bus.dmem_wr_en     = 1'b1;
                bus.dmem_data_size = ent_size[head];
                bus.dmem_addr      = ent_addr[head];
                bus.dmem_wr_data   = ent_data[head];
            end
            // Store readiness depends only on the registered count, never on pop.
            if (is_store) begin
                bus.lsu_ready = can_push;
            end
`ifdef STORE_BUF_FWD_EN
            if (fwd_hit) begin
                bus.lsu_ready   = 1'b1;
                bus.lsu_rd_data = fwd_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry contents need no reset; only head/tail/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= bus.lsu_addr;
            ent_size[tail] <= bus.lsu_data_size;
            ent_data[tail] <= bus.lsu_wr_data;
        end
    end

    assign sb_count = count;
    assign sb_empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import risc_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if bus ();
    logic [CNT_W-1:0] sb_count;
    logic             sb_empty;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        mem_size_t   size;
        logic [31:0] data;
    } ent_t;

    ent_t       q[$];
    logic [7:0] mem     [4096] = '{default: 8'h00};
    logic [7:0] ref_mem [4096] = '{default: 8'h00};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input mem_size_t s);
        return (s == BYTE) ? 1 : (s == HALF_WORD) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] raw, input mem_size_t s, input logic zx);
        case (s)
            BYTE:      return zx ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            HALF_WORD: return zx ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:   return raw;
        endcase
    endfunction

    function automatic bit covers(input ent_t e, input logic [31:0] a);
        return (longint'(a) >= longint'(e.addr)) &&
               (longint'(a) < longint'(e.addr) + longint'(nbytes(e.size)));
    endfunction

    // Index of the youngest pending store sharing any byte with the access, or -1.
    function automatic int young_ovl(input logic [31:0] a, input mem_size_t s);
        int idx = -1;
        for (int i = 0; i < q.size(); i++)
            for (int b = 0; b < nbytes(s); b++)
                if (covers(q[i], a + 32'(b))) idx = i;
        return idx;
    endfunction

    // Architectural load value: memory with every pending store applied in order.
    function automatic logic [31:0] model_load(input logic [31:0] a, input mem_size_t s, input logic zx);
        logic [31:0] raw = '0;
        for (int b = 0; b < 4; b++) begin
            logic [31:0] ba;
            logic [7:0]  v;
            ba = a + 32'(b);
            v  = ref_mem[ba[11:0]];
            for (int i = 0; i < q.size(); i++)
                if (covers(q[i], ba)) v = q[i].data[8*int'(ba - q[i].addr) +: 8];
            raw[8*b +: 8] = v;
        end
        return ext(raw, s, zx);
    endfunction

    // Data memory: combinational read, write on the rising edge.
    always_comb begin
        logic [11:0] a;
        a = bus.dmem_addr[11:0];
        bus.dmem_rd_data = ext({mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]},
                               bus.dmem_data_size, bus.dmem_zero_extend);
    end

    always @(posedge clk) begin
        if (rst_n && bus.dmem_req && bus.dmem_wr_en) begin
            mem[bus.dmem_addr[11:0]] <= bus.dmem_wr_data[7:0];
            if (bus.dmem_data_size != BYTE)
                mem[bus.dmem_addr[11:0] + 12'd1] <= bus.dmem_wr_data[15:8];
            if (bus.dmem_data_size == WORD) begin
                mem[bus.dmem_addr[11:0] + 12'd2] <= bus.dmem_wr_data[23:16];
                mem[bus.dmem_addr[11:0] + 12'd3] <= bus.dmem_wr_data[31:24];
            end
        end
    end

    // Compare process: checks every cycle, then advances the model to the next edge.
    always @(negedge clk) begin
        int  yi;
        int  occ;
        bit  is_ld, is_st, fwd, exp_rdy, ld_port;
        if (!rst_n) begin
            q.delete();
            chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
            chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
            chk("rst_rd_data", bus.lsu_rd_data, 32'd0);
            chk("rst_count", 32'(sb_count), 32'd0);
        end else begin
            occ   = q.size();
            is_ld = bus.lsu_req && !bus.lsu_wr_en;
            is_st = bus.lsu_req && bus.lsu_wr_en;
            yi    = is_ld ? young_ovl(bus.lsu_addr, bus.lsu_data_size) : -1;
            fwd   = 1'b0;
`ifdef STORE_BUF_FWD_EN
            if (yi >= 0)
                fwd = (q[yi].addr == bus.lsu_addr) && (q[yi].size == bus.lsu_data_size);
`endif
            ld_port = is_ld && (yi < 0);
            exp_rdy = is_st ? (occ < DEPTH) : (ld_port || fwd);

            chk("sb_count", 32'(sb_count), 32'(occ));
            chk("sb_empty", 32'(sb_empty), 32'(occ == 0));
            if (bus.lsu_req) chk("lsu_ready", 32'(bus.lsu_ready), 32'(exp_rdy));
            if (is_ld && exp_rdy)
                chk("load_data", bus.lsu_rd_data,
                    model_load(bus.lsu_addr, bus.lsu_data_size, bus.lsu_zero_extend));
            if (ld_port) begin
                chk("ld_dmem_req", 32'(bus.dmem_req), 32'd1);
                chk("ld_dmem_wr_en", 32'(bus.dmem_wr_en), 32'd0);
                chk("ld_dmem_addr", bus.dmem_addr, bus.lsu_addr);
                chk("ld_dmem_size", 32'(bus.dmem_data_size), 32'(bus.lsu_data_size));
                chk("ld_dmem_zx", 32'(bus.dmem_zero_extend), 32'(bus.lsu_zero_extend));
            end else if (occ > 0) begin
                chk("wr_dmem_req", 32'(bus.dmem_req), 32'd1);
                chk("wr_dmem_wr_en", 32'(bus.dmem_wr_en), 32'd1);
                chk("wr_dmem_addr", bus.dmem_addr, q[0].addr);
                chk("wr_dmem_size", 32'(bus.dmem_data_size), 32'(q[0].size));
                chk("wr_dmem_data", bus.dmem_wr_data, q[0].data);
                chk("wr_dmem_zx", 32'(bus.dmem_zero_extend), 32'd0);
            end else begin
                chk("idle_dmem_req", 32'(bus.dmem_req), 32'd0);
                chk("idle_dmem_addr", bus.dmem_addr, 32'd0);
                chk("idle_dmem_data", bus.dmem_wr_data, 32'd0);
            end

            if (!ld_port && occ > 0) begin
                for (int b = 0; b < nbytes(q[0].size); b++) begin
                    logic [31:0] ba;
                    ba = q[0].addr + 32'(b);
                    ref_mem[ba[11:0]] = q[0].data[8*b +: 8];
                end
                void'(q.pop_front());
            end
            if (is_st && occ < DEPTH)
                q.push_back('{addr: bus.lsu_addr, size: bus.lsu_data_size, data: bus.lsu_wr_data});
        end
    end

    // Presents one request (held until accepted); returns one cycle after
    // acceptance with the request still driven, #1 after the edge.
    task automatic req(input logic wr, input mem_size_t s, input logic [31:0] a,
                       input logic [31:0] d, input logic zx,
                       output logic [31:0] rd, output int stalls);
        bit done = 0;
        bus.lsu_req = 1'b1;
        bus.lsu_wr_en = wr;
        bus.lsu_data_size = s;
        bus.lsu_addr = a;
        bus.lsu_wr_data = d;
        bus.lsu_zero_extend = zx;
        rd = '0;
        stalls = 0;
        while (!done && stalls < 50) begin
            @(negedge clk);
            if (bus.lsu_ready) begin
                rd = bus.lsu_rd_data;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) chk("req_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lsu_req = 1'b0;
        bus.lsu_wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        int st;
        bus.lsu_req = 1'b0;
        bus.lsu_wr_en = 1'b0;
        bus.lsu_data_size = BYTE;
        bus.lsu_addr = '0;
        bus.lsu_wr_data = '0;
        bus.lsu_zero_extend = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_sb_empty", 32'(sb_empty), 32'd1);
        chk("reset_sb_count", 32'(sb_count), 32'd0);
        chk("reset_dmem_req", 32'(bus.dmem_req), 32'd0);
        @(posedge clk);
        #1;

        // SB 0x101 = 0x7F, then LW 0x100 waits for the drain
        req(1'b1, BYTE, 32'h101, 32'h7F, 1'b0, rd, st);
        req(1'b0, WORD, 32'h100, 32'h0, 1'b0, rd, st);
        chk("sb_lw_data", rd, 32'h00007F00);
        chk("sb_lw_stall", 32'(st), 32'd1);
        idle();

        // SW 0x100 = 0xDEADBEEF on an idle buffer
        req(1'b1, WORD, 32'h100, 32'hDEADBEEF, 1'b0, rd, st);
        bus.lsu_req = 1'b0;
        @(negedge clk);
        chk("sw_port_req", 32'(bus.dmem_req), 32'd1);
        chk("sw_port_wr_en", 32'(bus.dmem_wr_en), 32'd1);
        chk("sw_port_addr", bus.dmem_addr, 32'h100);
        chk("sw_port_data", bus.dmem_wr_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sw_sb_empty", 32'(sb_empty), 32'd1);
        @(posedge clk);
        #1;
        req(1'b0, WORD, 32'h100, 32'h0, 1'b0, rd, st);
        chk("lw_after_sw", rd, 32'hDEADBEEF);
        chk("lw_after_sw_stall", 32'(st), 32'd0);

        // SH 0x200 = 0x8001 then LH / LHU / LW
        req(1'b1, HALF_WORD, 32'h200, 32'h8001, 1'b0, rd, st);
        req(1'b0, HALF_WORD, 32'h200, 32'h0, 1'b0, rd, st);
        chk("lh_data", rd, 32'hFFFF8001);
`ifdef STORE_BUF_FWD_EN
        chk("lh_stall", 32'(st), 32'd0);
`else
        chk("lh_stall", 32'(st), 32'd1);
`endif
        req(1'b1, HALF_WORD, 32'h204, 32'h8001, 1'b0, rd, st);
        req(1'b0, HALF_WORD, 32'h204, 32'h0, 1'b1, rd, st);
        chk("lhu_data", rd, 32'h00008001);
`ifdef STORE_BUF_FWD_EN
        chk("lhu_stall", 32'(st), 32'd0);
`else
        chk("lhu_stall", 32'(st), 32'd1);
`endif
        req(1'b1, HALF_WORD, 32'h208, 32'h8001, 1'b0, rd, st);
        req(1'b0, WORD, 32'h208, 32'h0, 1'b0, rd, st);
        chk("lw_partial_data", rd, 32'h00008001);
        chk("lw_partial_stall", 32'(st), 32'd1);
        idle();

        // Pending store held back by loads, then discarded by reset
        req(1'b1, WORD, 32'h300, 32'h12345678, 1'b0, rd, st);
        for (int i = 0; i < 3; i++) begin
            req(1'b0, WORD, 32'h800, 32'h0, 1'b0, rd, st);
            chk("starve_stall", 32'(st), 32'd0);
        end
        bus.lsu_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(sb_count), 32'd0);
        chk("midrst_empty", 32'(sb_empty), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) idle();
        chk("midrst_no_write", {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            mem_size_t s;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            s = mem_size_t'($urandom_range(0, 2));
            a = 32'h100 + (32'($urandom_range(0, 63)) & ~(32'(nbytes(s)) - 32'd1));
            if (n == 700) begin
                bus.lsu_req = 1'b0;
                rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else if (r < 2) begin
                idle();
            end else if (r == 2) begin
                req(1'b0, WORD, 32'h800, 32'h0, 1'b0, rd, st);
            end else begin
                req(1'($urandom_range(0, 1)), s, a, $urandom, 1'($urandom_range(0, 1)), rd, st);
            end
        end
        repeat (10) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the memory stage and `data_memory`. It accepts stores from the pipeline in a single cycle, queues them in a small FIFO, and drains them to data memory when the memory port is free. Loads are passed straight through to data memory with zero added latency. A load that overlaps a pending store stalls until that store has drained.

## Interface
Parameters:
- `DEPTH`, default 4: number of store entries; must be a power of two, at least 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lsu_req`  in  1  pipeline memory request valid.
- `lsu_wr_en`  in  1  1 = store, 0 = load.
- `lsu_data_size`  in  `mem_size_t`  access size: BYTE, HALF_WORD or WORD (`risc_pkg`).
- `lsu_addr`  in  32  byte address.
- `lsu_wr_data`  in  32  store data; low bytes are used for BYTE and HALF_WORD.
- `lsu_zero_extend`  in  1  load extension select: 1 = LBU/LHU, 0 = LB/LH.
- `lsu_ready`  out  1  request accepted this cycle. The pipeline holds the request while this is 0.
- `lsu_rd_data`  out  32  load result, valid when `lsu_req & ~lsu_wr_en & lsu_ready`.
- `dmem_req`, `dmem_wr_en`, `dmem_data_size`, `dmem_addr`, `dmem_wr_data`, `dmem_zero_extend`  out  1/1/`mem_size_t`/32/32/1  data memory port.
- `dmem_rd_data`  in  32  combinational read data from data memory.
- `sb_count`  out  `CNT_W`  occupied entries (registered).
- `sb_empty`  out  1  `sb_count == 0`; used by fence and `ecall` logic.

## Operation
- Storage: circular FIFO of `{addr, size, data}` entries with head/tail pointers and a count; head is the oldest entry.
- Overlap test: load byte range `[A, A+N-1]` versus each valid entry's range, with N = 1, 2 or 4. Ends are computed in 33 bits, so ranges do not wrap.
- Store accept:
  - `lsu_ready = 1` iff `count < DEPTH`.
  - On accept, the entry is written at tail on the next edge.
  - No combinational path exists from drain to store-ready.
- Load accept:
  - If no valid entry overlaps: the port is driven with the load (`dmem_req=1`, `dmem_wr_en=0`, fields copied), and `lsu_rd_data = dmem_rd_data` in the same cycle with `lsu_ready=1`.
  - If any entry overlaps: `lsu_ready=0`.
- Port arbitration, in priority order:
  1. A non-overlapping load owns the port.
  2. Otherwise, if `count > 0`, the head entry drives a write (`dmem_req=1`, `dmem_wr_en=1`, `dmem_zero_extend=0`) and is popped at the edge.
  3. Otherwise `dmem_req=0` and all other dmem outputs are 0.
- A stalled overlapping load does not block draining. Drain continues until the overlap clears, and the load completes on the first cycle with no overlap.
- Same-cycle store accept and drain pop leave count unchanged; both pointers advance.
- `lsu_req=0` cycles drain freely.
- Stores reach memory in program order; loads may bypass non-overlapping stores.

## Timing
- Reset (async assert, sync release): head = tail = 0, count = 0, `sb_empty=1`, `sb_count=0`.
- Outputs while in reset: `dmem_req=0`, `lsu_ready=0`, and all other outputs 0. Entry contents are don't-care.
- Reset mid-operation discards all pending stores.
- Store latency:
  - Accepted at edge T; the earliest write to memory is at edge T+1, when the entry is head and the port is free.
  - Store-to-memory on an idle buffer takes 1 cycle.
- Load latency: 0 cycles when there is no overlap (combinational through data memory). With an overlap, the load is delayed by the number of drain cycles needed.
- Full: a store at `count == DEPTH` sees `lsu_ready=0`. Drain pops one entry per free cycle, and the store is accepted on the cycle after count drops below `DEPTH`.
- A continuous stream of non-overlapping loads starves the drain. This is accepted; fences use `sb_empty`.

## Configuration
- `STORE_BUF_FWD_EN` defined: store-to-load forwarding.
  - Applies when the youngest overlapping entry has exactly the same address and size as the load, and no younger entry overlaps.
  - `lsu_rd_data` is that entry's data, sign- or zero-extended per size and `lsu_zero_extend`.
  - `lsu_ready=1`, no dmem read is issued, and the head drains in the same cycle.
  - Partial overlaps still stall.
- Not defined: every overlapping load stalls. No forwarding mux is built.

## Test plan
- Reset, then one SW `0x100 = 0xDEADBEEF` with idle pipeline -> write on the port the next cycle; `sb_empty` returns to 1 after 1 cycle.
- Four back-to-back stores with `DEPTH=4` while loads to `0x800` occupy the port -> `sb_count=4`; a fifth store sees `lsu_ready=0` until one drain occurs.
- Enqueue SB `0x101 = 0x7F`, then LW `0x100` -> stalls until that SB drains; with memory preloaded to 0, returns `0x00007F00`.
- With `STORE_BUF_FWD_EN`: SH `0x200 = 0x8001` pending, then LH `0x200` -> same-cycle `0xFFFF8001`. LHU returns `0x00008001`. LW `0x200` stalls.
- Same-cycle store accept and drain at `count=2` -> count stays 2 and memory write order matches issue order.
- Assert `rst_n` low with 3 entries pending -> `count=0` immediately, and no further dmem writes occur.
